// File: rtl/lm71_ctrl.sv
// LM71 SPI temperature sensor sequencer: 16-bit read followed by a 16-bit mode write.
// Define LM71_ALARM_EN to add the over_temp output and its hysteresis comparator.
module lm71_ctrl #(
  parameter int CLK_DIV       = 25,
  parameter int PERIOD_CYCLES = 25_000_000,
  parameter int ALARM_TEMP    = 2560,
  parameter int ALARM_HYST    = 160
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               shutdown,
  output logic               busy,
  output logic               valid,
  output logic signed [15:0] temp,
`ifdef LM71_ALARM_EN
  output logic               over_temp,
`endif
  output logic               temp_cs_n,
  output logic               temp_sc,
  output logic               temp_mosi,
  input  logic               temp_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || ALARM_HYST < 0 || ALARM_TEMP > 32767) begin : g_bad_param
    $error("lm71_ctrl: CLK_DIV must be >= 1 and alarm settings must fit a 16-bit sample");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t             state;
  logic [DW-1:0]      div_cnt;
  logic [5:0]         bit_cnt;
  logic [5:0]         bit_nxt;
  logic [15:0]        rx;
  logic [15:0]        cmd_sr;
  logic               pending;
  logic               tick;
  logic               half_done;
  logic signed [15:0] temp_nxt;

  assign half_done = (div_cnt == DIV_LAST);
  assign bit_nxt   = bit_cnt + 6'd1;
  assign temp_nxt  = {{2{rx[15]}}, rx[15:2]};

  // Free-running period counter; a tick is the cycle the counter wraps.
  if (PERIOD_CYCLES > 0) begin : g_period
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    logic [PW-1:0] period_cnt;

    assign tick = (period_cnt == PW'(PERIOD_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) period_cnt <= '0;
      else if (tick) period_cnt <= '0;
      else           period_cnt <= period_cnt + PW'(1);
    end
  end else begin : g_no_period
    assign tick = 1'b0;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values of their neighbours, as real flops do.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the receive shift register is cleared too, so a transaction cut
      // short by reset can never leak a partial sample into a later result.
      state     <= S_IDLE;
      pending   <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rx        <= '0;
      cmd_sr    <= '0;
      temp_cs_n <= 1'b1;
      temp_sc   <= 1'b0;
      temp_mosi <= 1'b1;
      busy      <= 1'b0;
      valid     <= 1'b0;
      temp      <= '0;
    end else begin
      valid <= 1'b0;
      if (state != S_IDLE) begin
        div_cnt <= half_done ? '0 : div_cnt + DW'(1);
        if (tick) pending <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (pending) begin
            state     <= S_SETUP;
            pending   <= 1'b0;
            temp_cs_n <= 1'b0;
            busy      <= 1'b1;
            cmd_sr    <= {16{shutdown}};
            div_cnt   <= '0;
            bit_cnt   <= '0;
          end else begin
            pending <= start | tick;
          end
        end

        S_SETUP: if (half_done) state <= S_SHIFT;

        S_SHIFT: begin
          if (half_done) begin
            if (!temp_sc) begin
              temp_sc <= 1'b1;
              if (!bit_cnt[4]) rx <= {rx[14:0], temp_miso};
            end else begin
              temp_sc <= 1'b0;
              if (bit_cnt == 6'd31) begin
                state     <= S_HOLD;
                temp_mosi <= 1'b1;
              end else begin
                bit_cnt <= bit_nxt;
                // Write phase: next command bit goes out as the low half starts.
                if (bit_nxt[4]) begin
                  temp_mosi <= cmd_sr[15];
                  cmd_sr    <= {cmd_sr[14:0], 1'b1};
                end
              end
            end
          end
        end

        S_HOLD: begin
          if (half_done) begin
            state     <= S_IDLE;
            temp_cs_n <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b1;
            temp      <= temp_nxt;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LM71_ALARM_EN
  localparam logic signed [15:0] ALARM_SET = 16'(ALARM_TEMP);
  localparam logic signed [15:0] ALARM_CLR = 16'(ALARM_TEMP - ALARM_HYST);

  // Alarm follows the sample being published, so it changes with valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      over_temp <= 1'b0;
    end else if (state == S_HOLD && half_done) begin
      if (temp_nxt >= ALARM_SET)     over_temp <= 1'b1;
      else if (temp_nxt < ALARM_CLR) over_temp <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/lm71_ctrl.md
# lm71_ctrl

Sequencer for the board's LM71 SPI temperature sensor (TEMP_CS_N / TEMP_SC / TEMP_MOSI / TEMP_MISO pins). On a software or periodic trigger it runs one 32-clock LM71 transaction: a 16-bit temperature read, then a 16-bit command write that selects continuous conversion or shutdown. It presents the result as a sign-extended sample with a one-cycle valid strobe. It sits in the board top between the core clock/reset and the sensor pins, replacing the constant tie-offs on those pins.

## Interface
- CLK_DIV, 25: SC half-period in clk cycles (≥1); 25 gives 1 MHz SC at 50 MHz.
- PERIOD_CYCLES, 25_000_000: auto-trigger interval in clk cycles; 0 disables auto-trigger.
- ALARM_TEMP, 2560: over-temperature threshold in LSBs of 0.03125 °C (80 °C). Used only with LM71_ALARM_EN.
- ALARM_HYST, 160: alarm release hysteresis in LSBs (5 °C). Used only with LM71_ALARM_EN.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle trigger request.
- shutdown  in  1  command selector, sampled at transaction start: 1 writes 0xFFFF (shutdown), 0 writes 0x0000 (continuous).
- busy  out  1  transaction in progress.
- valid  out  1  one-cycle strobe; temp updated.
- temp  out  16  signed temperature, LSB = 0.03125 °C, sign-extended from 14 bits.
- over_temp  out  1  alarm level. Port exists only with LM71_ALARM_EN.
- temp_cs_n  out  1  sensor chip select.
- temp_sc  out  1  sensor serial clock.
- temp_mosi  out  1  command data; drives 1 (released) outside the write phase.
- temp_miso  in  1  sensor data.

## Operation
- Reset values: temp_cs_n=1, temp_sc=0, temp_mosi=1, busy=0, valid=0, temp=0, over_temp=0, period counter=0, pending=0.
- Triggers:
  - start while IDLE.
  - Period tick: the counter counts 0..PERIOD_CYCLES-1 continuously and ticks on wrap.
  - A tick during busy sets pending (at most one). Pending is consumed on the first IDLE cycle.
  - start during busy is ignored.
  - start and tick in the same cycle yield a single transaction.
- States:
  - IDLE → SETUP on trigger: cs_n←0, busy←1, latch command word from shutdown.
  - SETUP: CLK_DIV cycles with SC low → SHIFT.
  - SHIFT: 32 SC periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - Bits 0–15 (read): sample temp_miso into the shift register MSB-first on the clk edge where SC goes high.
    - Bits 16–31 (write): present the command MSB-first on temp_mosi, updated at the start of each low half.
  - After the 32nd high half → HOLD: CLK_DIV cycles, SC low, temp_mosi=1.
  - HOLD → IDLE: cs_n←1, busy←0, valid←1, temp←{{2{rx[15]}}, rx[15:2]}. rx[1:0] are discarded.
- SC never toggles while cs_n=1.
- The 6-bit bit counter and the CLK_DIV half-period counter are the only counters inside a transaction.
- Async reset mid-transaction: all outputs go to reset values immediately, and the partial sample is discarded.

## Timing
- start sampled at edge k → cs_n=0 and busy=1 after edge k+1.
- valid, cs_n=1 and busy=0 after edge k+1+66·CLK_DIV.
- The next transaction can begin one cycle after valid.
- With CLK_DIV=1 the SC frequency is clk/2. The integrator must keep SC ≤ 6.25 MHz (LM71 limit).
- temp holds its value until the next valid.

## Configuration
- LM71_ALARM_EN defined:
  - over_temp port and comparator are present.
  - over_temp sets on a valid with temp ≥ ALARM_TEMP.
  - over_temp clears on a valid with temp < ALARM_TEMP−ALARM_HYST; otherwise it holds.
  - The comparison is signed.
- LM71_ALARM_EN undefined:
  - no over_temp port and no comparator logic.
  - All other behaviour is identical.

## Test plan
- CLK_DIV=2, PERIOD_CYCLES=0; start pulse; model returns 0x0C83 → valid exactly 133 cycles after start, temp=0x0320 (25 °C), busy high for 132 cycles.
- Model returns 0xF383 → temp=0xFCE0 (−25 °C). With shutdown=1 the captured MOSI bits 16–31 are 0xFFFF; with shutdown=0 they are 0x0000. MOSI is 1 during bits 0–15.
- PERIOD_CYCLES=200, CLK_DIV=2: valid strobes repeat every 200 cycles. A start issued mid-transaction is ignored (no extra valid). A tick landing during busy starts a transaction on the first IDLE cycle.
- Assert reset_n low at SC period 10: cs_n=1, sc=0 and busy=0 without waiting for a clock edge. No valid is produced. After release, a new start yields a correct sample.
- With LM71_ALARM_EN: samples 2560 → over_temp=1; 2450 → stays 1; 2399 → 0.
- Protocol checker throughout: SC never toggles with cs_n=1, and exactly 32 rising SC edges occur per cs_n low window.
